// File: rtl/spi_slave.sv
// spi_slave: SPI target controller, all four CPOL/CPHA modes, MSB-first
// 8-bit full-duplex transfers with back-to-back bytes under one ss_n low.
// Pins are oversampled in the clk domain through SYNC_STAGES flops.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (sticky rx_overrun flag).
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       busy,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]             state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_n_sync, mosi_sync;
  logic                   sclk_s, ss_n_s, mosi_s;
  logic                   sclk_d, ss_n_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_byte;
  logic [7:0]             tx_buf;
  logic [7:0]             load_byte;
  logic                   lead_edge, trail_edge, sample_edge, out_edge;
  logic                   ss_fall, ss_rise;
  logic                   byte_done, byte_load;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign busy   = (state == ST_ACTIVE);

  // Pin synchronizers plus one delay stage on sclk/ss_n for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_n_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_n_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_n_d    <= ss_n_s;
    end
  end

  // Edge classification relative to the idle clock level, and byte events
  always_comb begin
    lead_edge   = (sclk_s != cpol) && (sclk_d == cpol);
    trail_edge  = (sclk_s == cpol) && (sclk_d != cpol);
    sample_edge = cpha ? trail_edge : lead_edge;
    out_edge    = cpha ? lead_edge : trail_edge;
    ss_fall     = ss_n_d && !ss_n_s;
    ss_rise     = !ss_n_d && ss_n_s;
    byte_done   = (state == ST_ACTIVE) && !ss_rise && sample_edge && (bit_cnt == 3'd7);
    byte_load   = ((state == ST_IDLE) && ss_fall) || byte_done;
    load_byte   = tx_ready ? 8'h00 : tx_buf;
  end

  // Transaction FSM: bit counter, shift registers and MISO drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_byte  <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (ss_fall) begin
            tx_byte <= load_byte;
            miso    <= load_byte[7];
            miso_oe <= 1'b1;
            state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (byte_done) tx_byte <= load_byte;
          end else if (out_edge) begin
            // bit_cnt is 0 on the first cpha=1 leading edge, re-driving bit 7
            miso <= tx_byte[3'd7 - bit_cnt];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry TX buffer; a host write wins the slot over a concurrent drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (tx_load && tx_ready) begin
      tx_buf   <= tx_data;
      tx_ready <= 1'b0;
    end else if (byte_load) begin
      tx_ready <= 1'b1;
    end
  end

  // Received byte register and valid handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (byte_done) begin
      rx_data  <= {rx_shift[6:0], mosi_s};
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Sticky overrun: set by an unacknowledged overwrite, ack takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun <= 1'b0;
    end else if (rx_ack) begin
      rx_overrun <= 1'b0;
    end else if (byte_done && rx_valid) begin
      rx_overrun <= 1'b1;
    end
  end
`else
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives spi_slave as an SPI master and checks both data
// directions against a transaction-level expectation model.
module tb_spi_slave;

  localparam int HP = 8;  // SPI half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       busy;
  logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic       miso, miso_oe;

  int checks = 0;
  int errors = 0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .busy(busy),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       load;
    logic [7:0] txb;
    logic [7:0] mosib;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vec [5];

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) chk("tx_ready_timeout", 8'(tx_ready), 8'h01);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Master shifts n bits MSB-first, sampling miso at its sample edge
  task automatic spi_bits(input logic [7:0] out, input int n, output logic [7:0] in);
    in = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = out[7-i];
        cyc(HP);
        in[7-i] = miso;
        sclk = ~cpol;
        cyc(HP);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = out[7-i];
        cyc(HP);
        in[7-i] = miso;
        sclk = cpol;
        cyc(HP);
      end
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    cyc(6);
  endtask

  // One complete single-byte transaction under its own ss_n low
  task automatic xfer1(input logic pol, input logic pha, input logic ld,
                       input logic [7:0] txb, input logic [7:0] mb,
                       output logic [7:0] got);
    set_mode(pol, pha);
    if (ld) load_tx(txb);
    ss_n = 1'b0;
    cyc(HP);
    spi_bits(mb, 8, got);
    cyc(HP);
    ss_n = 1'b1;
    cyc(6);
  endtask

  initial begin
    logic [7:0] got, got0, got1;
    logic       p, h, ld;
    logic [7:0] tb_tx, tb_mo, exp_mi;

    vec[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vec[1] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vec[2] = '{1'b0, 1'b0, 1'b0, 8'hEE, 8'h55, 8'h00, 8'h55};
    vec[3] = '{1'b1, 1'b0, 1'b1, 8'h6B, 8'hD2, 8'h6B, 8'hD2};
    vec[4] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h80, 8'h00, 8'h80};

    // Reset state
    cyc(3);
    chk("rst_tx_ready", 8'(tx_ready), 8'h01);
    chk("rst_rx_data",  rx_data, 8'h00);
    chk("rst_rx_valid", 8'(rx_valid), 8'h00);
    chk("rst_busy",     8'(busy), 8'h00);
    chk("rst_miso_oe",  8'(miso_oe), 8'h00);
    reset = 1'b0;
    cyc(6);

    // Table-driven single-byte transfers across modes, loaded and empty
    for (int i = 0; i < 5; i++) begin
      xfer1(vec[i].cpol, vec[i].cpha, vec[i].load, vec[i].txb, vec[i].mosib, got);
      chk($sformatf("vec%0d_miso", i), got, vec[i].exp_miso);
      chk($sformatf("vec%0d_rx", i), rx_data, vec[i].exp_rx);
      chk($sformatf("vec%0d_valid", i), 8'(rx_valid), 8'h01);
      chk($sformatf("vec%0d_tx_ready", i), 8'(tx_ready), 8'h01);
      chk($sformatf("vec%0d_oe_off", i), 8'(miso_oe), 8'h00);
      ack;
      cyc(1);
      chk($sformatf("vec%0d_valid_clr", i), 8'(rx_valid), 8'h00);
    end

    // Randomized transfers against the transaction model
    for (int i = 0; i < 12; i++) begin
      p = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      tb_tx = 8'($urandom);
      tb_mo = 8'($urandom);
      exp_mi = ld ? tb_tx : 8'h00;
      xfer1(p, h, ld, tb_tx, tb_mo, got);
      chk($sformatf("rnd%0d_miso", i), got, exp_mi);
      chk($sformatf("rnd%0d_rx", i), rx_data, tb_mo);
      ack;
    end

    // Burst in mode 1: second byte loaded once the first drains
    set_mode(1'b0, 1'b1);
    load_tx(8'h12);
    ss_n = 1'b0;
    cyc(1);
    load_tx(8'h34);
    cyc(HP);
    chk("burst_busy", 8'(busy), 8'h01);
    chk("burst_oe", 8'(miso_oe), 8'h01);
    spi_bits(8'hF0, 8, got0);
    cyc(HP);
    chk("burst_rx0", rx_data, 8'hF0);
    chk("burst_valid0", 8'(rx_valid), 8'h01);
    ack;
    spi_bits(8'h0F, 8, got1);
    cyc(HP);
    chk("burst_rx1", rx_data, 8'h0F);
    chk("burst_valid1", 8'(rx_valid), 8'h01);
    ack;
    ss_n = 1'b1;
    cyc(6);
    chk("burst_miso0", got0, 8'h12);
    chk("burst_miso1", got1, 8'h34);
    chk("burst_tx_ready", 8'(tx_ready), 8'h01);

    // Abort after 4 sample edges, then a clean transfer
    set_mode(1'b0, 1'b0);
    ss_n = 1'b0;
    cyc(HP);
    spi_bits(8'hFF, 4, got);
    cyc(HP);
    ss_n = 1'b1;
    cyc(6);
    chk("abort_valid", 8'(rx_valid), 8'h00);
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_oe", 8'(miso_oe), 8'h00);
    xfer1(1'b0, 1'b0, 1'b1, 8'h5A, 8'hC3, got);
    chk("post_abort_rx", rx_data, 8'hC3);
    chk("post_abort_miso", got, 8'h5A);
    ack;

    // Overrun: two bytes without acknowledgement
    xfer1(1'b1, 1'b0, 1'b0, 8'h00, 8'hA1, got);
    chk("ovr_none", 8'(rx_overrun), 8'h00);
    xfer1(1'b1, 1'b0, 1'b0, 8'h00, 8'hB2, got);
    chk("ovr_rx", rx_data, 8'hB2);
    chk("ovr_valid", 8'(rx_valid), 8'h01);
    chk("ovr_flag", 8'(rx_overrun), 8'(OVR_EXP));
    ack;
    cyc(1);
    chk("ovr_valid_clr", 8'(rx_valid), 8'h00);
    chk("ovr_flag_clr", 8'(rx_overrun), 8'h00);

    // Reset mid-byte with a byte still held in the TX buffer
    set_mode(1'b0, 1'b0);
    load_tx(8'h99);
    ss_n = 1'b0;
    cyc(2);
    load_tx(8'h77);
    cyc(HP);
    spi_bits(8'hAA, 4, got);
    chk("pre_rst_tx_ready", 8'(tx_ready), 8'h00);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_tx_ready", 8'(tx_ready), 8'h01);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_valid", 8'(rx_valid), 8'h00);
    chk("mid_rst_ovr", 8'(rx_overrun), 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_miso", 8'(miso), 8'h00);
    chk("mid_rst_oe", 8'(miso_oe), 8'h00);
    ss_n = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    xfer1(1'b0, 1'b0, 1'b0, 8'h00, 8'h3E, got);
    chk("post_rst_miso", got, 8'h00);
    chk("post_rst_rx", rx_data, 8'h3E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (target) controller: the responding end of the team's SPI link. It oversamples `sclk`, `ss_n` and `mosi` in the `clk` domain, supports all four CPOL/CPHA modes, and performs MSB-first 8-bit full-duplex transfers. Back-to-back bytes are supported while `ss_n` stays low. A one-entry TX buffer and a held RX register decouple the byte stream from the host-side logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `ss_n` and `mosi` (minimum 2).
- `clk`  in  1  system clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `cpol`  in  1  clock polarity; must be static while `busy`=1.
- `cpha`  in  1  clock phase; must be static while `busy`=1.
- `tx_data`  in  8  byte offered to the TX buffer.
- `tx_load`  in  1  write strobe; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  TX buffer empty.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unacknowledged byte.
- `rx_ack`  in  1  host consumes `rx_data`.
- `rx_overrun`  out  1  sticky overrun flag; see Configuration.
- `busy`  out  1  transaction active (ACTIVE state).
- `sclk`  in  1  SPI clock from the master.
- `mosi`  in  1  master out, slave in.
- `ss_n`  in  1  slave select, active low.
- `miso`  out  1  slave out; reads 0 when `miso_oe`=0.
- `miso_oe`  out  1  MISO output enable (tri-state control).

## Operation
- **Synchronization:** `sclk`, `ss_n` and `mosi` each pass through `SYNC_STAGES` flops. One extra register on `sclk_s` and `ss_n_s` provides edge detection.
- **Edge definitions:**
  - Leading edge: `sclk_s` leaves the `cpol` level.
  - Trailing edge: `sclk_s` returns to the `cpol` level.
  - Sample edge: leading edge when `cpha`=0; trailing edge when `cpha`=1.
  - Output edge: the other edge.
- **State IDLE:**
  - `busy`=0, `miso_oe`=0, `miso`=0, `bit_cnt`=0.
  - On a falling edge of `ss_n_s`: load the byte (see Byte load), set `miso` to `tx_byte[7]`, set `miso_oe`=1, go to ACTIVE.
- **State ACTIVE:**
  - On a sample edge: `rx_shift` takes `{rx_shift[6:0], mosi_s}` and `bit_cnt` increments, wrapping 7→0.
  - On the 8th sample edge:
    - `rx_data` takes the complete byte and `rx_valid` is set to 1.
    - The next byte is loaded per Byte load.
  - On an output edge: `miso` takes `tx_byte[7-bit_cnt]`. For `cpha`=1 the first leading edge re-drives bit 7.
  - On a rising edge of `ss_n_s`: go to IDLE.
    - A partial byte is discarded: no `rx_valid`, and `bit_cnt` is cleared.
    - `miso_oe` goes to 0.
    - An unconsumed TX buffer is retained.
- **Byte load:**
  - If `tx_ready`=0: `tx_byte` takes the buffer and the buffer empties, so `tx_ready`=1 next cycle.
  - Otherwise `tx_byte` takes 8'h00.
- **TX buffer:**
  - `tx_load` with `tx_ready`=1 captures `tx_data`; `tx_ready`=0 next cycle.
  - `tx_load` with `tx_ready`=0 is ignored.
  - Byte load and `tx_load` in the same cycle with `tx_ready`=1: the byte load takes 8'h00 and `tx_data` is captured.
- **RX handshake:**
  - `rx_ack` clears `rx_valid` next cycle.
  - A completion in the same cycle as `rx_ack`: the new byte is presented and `rx_valid` stays 1.
  - A completion while `rx_valid`=1 without `rx_ack` overwrites `rx_data`.
- **Reset values:** `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `rx_overrun`=0, `busy`=0, `miso`=0, `miso_oe`=0, state IDLE, all shift registers and counters 0.
- **Reset mid-transaction:** immediate return to these values; the buffered TX byte is lost.

## Timing
- A pin edge takes effect in registered outputs (`miso`, `rx_data`, `rx_valid`, `busy`, `miso_oe`) `SYNC_STAGES`+1 `clk` edges after it is first sampled.
- `mosi` has the same latency as `sclk`, so sampling is aligned.
- Requirements on the master:
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` cycles.
  - `ss_n` low to first `sclk` edge ≥ `SYNC_STAGES`+2 `clk` cycles.
- `tx_ready` and `rx_valid` change one cycle after the triggering strobe or event.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - `rx_overrun` is set when a byte completes while `rx_valid`=1 and `rx_ack`=0.
  - `rx_overrun` is cleared by `rx_ack`.
  - Set and clear in the same cycle: the flag clears.
- Undefined: `rx_overrun` is tied to 0 and the overrun logic is absent. The port remains.

## Test plan
- Mode 0 (cpol=0, cpha=0): load 0xA5; master sends 0x3C → `rx_data`=0x3C with `rx_valid`=1; master receives 0xA5; `tx_ready` returns to 1.
- Mode 3 (cpol=1, cpha=1): load 0x81; master sends 0x7E → `rx_data`=0x7E; master receives 0x81.
- Burst in mode 1: load 0x12, then load 0x34 after `tx_ready` rises; master sends 0xF0, 0x0F under one `ss_n` low → master receives 0x12, 0x34; two `rx_valid` events, with 0xF0 and 0x0F each acked.
- Empty buffer: no `tx_load`; master sends 0x55 → master receives 0x00; `rx_data`=0x55.
- Abort: `ss_n` deasserted after 4 sample edges → no `rx_valid`, `busy`=0, `miso_oe`=0; the next full transfer of 0xC3 is received correctly.
- Overrun: two bytes received without `rx_ack` → `rx_data` holds the second byte and `rx_overrun`=1 (0 without the macro); `rx_ack` clears both. Assert `reset` mid-byte → all outputs at their reset values.
